_genrom_rd: RTL and testbench
=============================

_GENROM_RD -- requirements
Module: _genrom_rd

Interface
REQ-001 Parameters SHALL be, one per line:
  WIDTH, 4, ROM data width in bits
  HEIGHT, 8, ROM address width in bits
  WAIT, 1, ROM access cycles with chip selects asserted before data capture; legal range 1..15
REQ-002 Ports SHALL be, one per line:
  cp  input  1  clock; all state changes on the rising edge
  rst  input  1  synchronous reset, active-high
  req_valid  input  1  read request present
  req_ready  output  1  request accepted when high together with req_valid
  req_addr  input  HEIGHT  word address to read
  rom_a  output  HEIGHT  address to the ROM
  rom_cs1_  output  1  ROM chip select 1, active-low
  rom_cs2_  output  1  ROM chip select 2, active-low
  rom_q  input  WIDTH  ROM data, high-Z when the ROM is deselected
  rsp_valid  output  1  read data available
  rsp_ready  input  1  consumer takes data when high together with rsp_valid
  rsp_data  output  WIDTH  captured read data
  busy  output  1  high in ACCESS or HOLD

Function
REQ-003 The block SHALL implement exactly three states: IDLE, ACCESS, HOLD.
REQ-004 req_ready SHALL be 1 in IDLE, 1 in HOLD only when rsp_ready=1, and 0 otherwise.
REQ-005 On a request handshake, req_addr SHALL be latched into rom_a, the wait counter SHALL load WAIT-1, and the state SHALL become ACCESS.
REQ-006 rom_cs1_ and rom_cs2_ SHALL both be 0 in ACCESS and both be 1 in IDLE and HOLD.
REQ-007 In ACCESS the counter SHALL decrement each cycle; on the edge where it equals 0, rom_q SHALL be captured into rsp_data and the state SHALL become HOLD.
REQ-008 Latency SHALL be WAIT+1 cycles from the handshake cycle to the first cycle with rsp_valid=1.
REQ-009 rsp_valid SHALL be 1 only in HOLD; rsp_data SHALL remain stable until the rsp handshake.
REQ-010 In HOLD with rsp_ready=1 and req_valid=0, the state SHALL return to IDLE.
REQ-011 In HOLD with rsp_ready=1 and req_valid=1, the state SHALL pass directly to ACCESS with the new address, giving a throughput of one word per WAIT+1 cycles.
REQ-012 rom_a SHALL change only on a request handshake; it SHALL hold its value in IDLE and HOLD.
REQ-013 req_addr and req_valid SHALL be ignored in ACCESS; there is no abort.
REQ-014 rsp_data SHALL be captured bit-exact; a Z or X on rom_q SHALL propagate into rsp_data without masking.

Reset
REQ-015 With rst=1 at a rising edge, the block SHALL enter IDLE with rom_a=0, counter=0, rsp_data=0, rsp_valid=0, busy=0, and rom_cs1_=rom_cs2_=1; this holds from any state, including mid-ACCESS.
REQ-016 While rst=1, req_ready SHALL be 0 and no handshake SHALL be accepted.

Configuration
REQ-017 The macro SHALL be GENROM_RD_PARITY_EN.
REQ-018 With GENROM_RD_PARITY_EN defined, the block SHALL add an output rsp_perr (1 bit). rsp_perr is computed at capture as the XOR of all WIDTH bits of rom_q (even parity including the MSB check bit), is valid only in HOLD, and is otherwise 0; it resets to 0.
REQ-019 Without GENROM_RD_PARITY_EN, the rsp_perr port SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-020 The bench SHALL cover the following directed scenarios, one per line:
  WIDTH=4, HEIGHT=8, WAIT=1, ROM[0x12]=0xA; request 0x12 -> cs low for 1 cycle, rsp_valid=1 two cycles after the handshake, rsp_data=0xA.
  WAIT=3, request 0x05 with ROM[5]=0x3 -> cs low for exactly 3 cycles, rsp_data=0x3 at latency 4.
  rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_data are stable, cs stays 1, req_ready=0.
  Chained reads 0x00, 0x01, 0x02 with rsp_ready=1 and req_valid=1 throughout, WAIT=1 -> three responses two cycles apart, in order.
  rst pulsed in the second ACCESS cycle at WAIT=3 -> next cycle is IDLE, cs=1, rsp_valid never asserts, and a subsequent read completes normally.
  With GENROM_RD_PARITY_EN, ROM word 0b0111 -> rsp_perr=1; word 0b0110 -> rsp_perr=0.

Source files
------------

// File: rtl/_genrom_rd.sv
// Read sequencer for an asynchronous ROM: latches an address, holds both chip
// selects low for WAIT cycles, captures the word and presents it until taken.
// Optional build macro GENROM_RD_PARITY_EN adds the rsp_perr parity output.
module _genrom_rd #(
  parameter int WIDTH  = 4,
  parameter int HEIGHT = 8,
  parameter int WAIT   = 1
) (
  input  logic              cp,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [HEIGHT-1:0] req_addr,
  output logic [HEIGHT-1:0] rom_a,
  output logic              rom_cs1_,
  output logic              rom_cs2_,
  input  logic [WIDTH-1:0]  rom_q,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_data,
  output logic              busy
`ifdef GENROM_RD_PARITY_EN
  ,
  output logic              rsp_perr
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT - 1);

  state_t     state;
  state_t     state_nx;
  logic [3:0] cnt;
  logic       load;
  logic       perr_q;

  // A new request may start from IDLE, or from HOLD in the same cycle the
  // current word is taken, which gives back-to-back reads with no idle gap.
  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !rst;
        if (req_valid && !rst) begin
          load     = 1'b1;
          state_nx = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          state_nx = HOLD;
        end
      end
      HOLD: begin
        req_ready = rsp_ready && !rst;
        if (rsp_ready) begin
          if (req_valid) begin
            load     = 1'b1;
            state_nx = ACCESS;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge cp) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // rom_q is captured unmasked so undriven or unknown bits reach rsp_data.
  always_ff @(posedge cp) begin
    if (rst) begin
      rom_a    <= '0;
      cnt      <= 4'd0;
      rsp_data <= '0;
      perr_q   <= 1'b0;
    end else if (load) begin
      rom_a <= req_addr;
      cnt   <= CNT_LOAD;
    end else if (state == ACCESS) begin
      if (cnt == 4'd0) begin
        rsp_data <= rom_q;
        perr_q   <= ^rom_q;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  assign rom_cs1_  = (state != ACCESS);
  assign rom_cs2_  = (state != ACCESS);
  assign rsp_valid = (state == HOLD);
  assign busy      = (state != IDLE);

`ifdef GENROM_RD_PARITY_EN
  assign rsp_perr = (state == HOLD) && perr_q;
`endif

endmodule

// File: tb/tb__genrom_rd.sv
// Scoreboard bench for _genrom_rd: two instances (WAIT=1 and WAIT=3) each read
// a shared ROM model; expected words are queued on request and checked on response.
module tb__genrom_rd;

  logic cp = 1'b0;
  always #5 cp = ~cp;

  logic            rst;
  logic [1:0]      req_valid;
  logic [1:0]      rsp_ready;
  logic [1:0][7:0] req_addr;
  wire  [1:0]      req_ready;
  wire  [1:0]      cs1;
  wire  [1:0]      cs2;
  wire  [1:0]      rsp_valid;
  wire  [1:0]      busy;
  wire  [1:0][7:0] rom_a;
  wire  [1:0][3:0] rsp_data;
  wire  [3:0]      rom_q0;
  wire  [3:0]      rom_q1;
`ifdef GENROM_RD_PARITY_EN
  wire  [1:0]      rsp_perr;
`endif

  logic [3:0] mem [256];
  int         total = 0;
  int         bad   = 0;
  logic [4:0] exp_q0[$];
  logic [4:0] exp_q1[$];
  logic [4:0] item;

  assign rom_q0 = (!cs1[0] && !cs2[0]) ? mem[rom_a[0]] : 4'bzzzz;
  assign rom_q1 = (!cs1[1] && !cs2[1]) ? mem[rom_a[1]] : 4'bzzzz;

  _genrom_rd #(.WIDTH(4), .HEIGHT(8), .WAIT(1)) u_dut0 (
    .cp(cp), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .rom_a(rom_a[0]), .rom_cs1_(cs1[0]), .rom_cs2_(cs2[0]),
    .rom_q(rom_q0), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_data(rsp_data[0]), .busy(busy[0])
`ifdef GENROM_RD_PARITY_EN
    , .rsp_perr(rsp_perr[0])
`endif
  );

  _genrom_rd #(.WIDTH(4), .HEIGHT(8), .WAIT(3)) u_dut1 (
    .cp(cp), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .rom_a(rom_a[1]), .rom_cs1_(cs1[1]), .rom_cs2_(cs2[1]),
    .rom_q(rom_q1), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_data(rsp_data[1]), .busy(busy[1])
`ifdef GENROM_RD_PARITY_EN
    , .rsp_perr(rsp_perr[1])
`endif
  );

  function automatic int wait_of(input int idx);
    return (idx == 0) ? 1 : 3;
  endfunction

  function automatic logic [4:0] exp_word(input logic [7:0] a);
    return {^mem[a], mem[a]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, want, $time);
    end
  endtask

  // Scoreboard: pop before push so a HOLD->ACCESS chain pairs correctly.
  always @(negedge cp) begin
    if (!rst) begin
      if (rsp_valid[0] && rsp_ready[0]) begin
        if (exp_q0.size() == 0) checkOutput("rsp_unexpected0", 1, 0);
        else begin
          item = exp_q0.pop_front();
          checkOutput("rsp_data0", 32'(rsp_data[0]), 32'(item[3:0]));
`ifdef GENROM_RD_PARITY_EN
          checkOutput("rsp_perr0", 32'(rsp_perr[0]), 32'(item[4]));
`endif
        end
      end
      if (rsp_valid[1] && rsp_ready[1]) begin
        if (exp_q1.size() == 0) checkOutput("rsp_unexpected1", 1, 0);
        else begin
          item = exp_q1.pop_front();
          checkOutput("rsp_data1", 32'(rsp_data[1]), 32'(item[3:0]));
`ifdef GENROM_RD_PARITY_EN
          checkOutput("rsp_perr1", 32'(rsp_perr[1]), 32'(item[4]));
`endif
        end
      end
      if (req_valid[0] && req_ready[0]) exp_q0.push_back(exp_word(req_addr[0]));
      if (req_valid[1] && req_ready[1]) exp_q1.push_back(exp_word(req_addr[1]));
    end
  end

  task automatic checkIdleReset(input int idx, input string tag);
    checkOutput({tag, "_rom_a"}, 32'(rom_a[idx]), 0);
    checkOutput({tag, "_rsp_data"}, 32'(rsp_data[idx]), 0);
    checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid[idx]), 0);
    checkOutput({tag, "_busy"}, 32'(busy[idx]), 0);
    checkOutput({tag, "_cs1"}, 32'(cs1[idx]), 1);
    checkOutput({tag, "_cs2"}, 32'(cs2[idx]), 1);
`ifdef GENROM_RD_PARITY_EN
    checkOutput({tag, "_perr"}, 32'(rsp_perr[idx]), 0);
`endif
  endtask

  task automatic applyStimulus(input int idx, input logic [7:0] addr, input int hold);
    int         lat;
    int         cs_cnt;
    bit         got_hs;
    logic [3:0] want;
    want   = mem[addr];
    got_hs = 1'b0;
    @(posedge cp); #1;
    req_valid[idx] = 1'b1;
    req_addr[idx]  = addr;
    rsp_ready[idx] = 1'b0;
    for (int g = 0; g < 20; g++) begin
      @(negedge cp);
      if (req_ready[idx]) begin
        got_hs = 1'b1;
        break;
      end
    end
    if (!got_hs) begin
      checkOutput("hs_timeout", 0, 1);
      req_valid[idx] = 1'b0;
      return;
    end
    @(posedge cp); #1;
    req_valid[idx] = 1'b0;
    req_addr[idx]  = ~addr;
    lat    = 0;
    cs_cnt = 0;
    for (int g = 0; g < 40; g++) begin
      @(negedge cp);
      lat++;
      if (!cs1[idx]) begin
        cs_cnt++;
        checkOutput("rom_a_access", 32'(rom_a[idx]), 32'(addr));
      end
      if (rsp_valid[idx]) break;
    end
    checkOutput("latency", lat, wait_of(idx) + 1);
    checkOutput("cs_cycles", cs_cnt, wait_of(idx));
    for (int k = 0; k < hold; k++) begin
      checkOutput("hold_valid", 32'(rsp_valid[idx]), 1);
      checkOutput("hold_data", 32'(rsp_data[idx]), 32'(want));
      checkOutput("hold_cs1", 32'(cs1[idx]), 1);
      checkOutput("hold_cs2", 32'(cs2[idx]), 1);
      checkOutput("hold_req_ready", 32'(req_ready[idx]), 0);
      checkOutput("hold_rom_a", 32'(rom_a[idx]), 32'(addr));
`ifdef GENROM_RD_PARITY_EN
      checkOutput("hold_perr", 32'(rsp_perr[idx]), 32'(^want));
`endif
      @(negedge cp);
    end
    @(posedge cp); #1;
    rsp_ready[idx] = 1'b1;
    @(posedge cp); #1;
    rsp_ready[idx] = 1'b0;
    @(negedge cp);
    checkOutput("back_idle", 32'(busy[idx]), 0);
  endtask

  task automatic chainReads();
    int hs_n;
    int rsp_n;
    int t0, t1, t2;
    hs_n = 0; rsp_n = 0; t0 = 0; t1 = 0; t2 = 0;
    @(posedge cp); #1;
    rsp_ready[0] = 1'b1;
    req_valid[0] = 1'b1;
    req_addr[0]  = 8'h00;
    for (int c = 0; c < 30 && rsp_n < 3; c++) begin
      @(negedge cp);
      if (rsp_valid[0]) begin
        if (rsp_n == 0) t0 = c;
        else if (rsp_n == 1) t1 = c;
        else t2 = c;
        rsp_n++;
      end
      if (req_valid[0] && req_ready[0]) hs_n++;
      @(posedge cp); #1;
      if (hs_n >= 3) req_valid[0] = 1'b0;
      else req_addr[0] = 8'(hs_n);
    end
    rsp_ready[0] = 1'b0;
    req_valid[0] = 1'b0;
    checkOutput("chain_rsps", rsp_n, 3);
    checkOutput("chain_hs", hs_n, 3);
    checkOutput("chain_gap1", t1 - t0, 2);
    checkOutput("chain_gap2", t2 - t1, 2);
  endtask

  task automatic resetMidAccess();
    @(posedge cp); #1;
    req_valid[1] = 1'b1;
    req_addr[1]  = 8'h05;
    @(negedge cp);
    checkOutput("rma_ready", 32'(req_ready[1]), 1);
    @(posedge cp); #1;
    req_valid[1] = 1'b0;
    @(posedge cp); #1;
    rst = 1'b1;
    @(negedge cp);
    checkOutput("rma_busy_before", 32'(busy[1]), 1);
    checkOutput("rma_ready_in_rst", 32'(req_ready[1]), 0);
    @(posedge cp); #1;
    rst = 1'b0;
    exp_q1.delete();
    @(negedge cp);
    checkIdleReset(1, "rma");
    for (int k = 0; k < 6; k++) begin
      checkOutput("rma_no_valid", 32'(rsp_valid[1]), 0);
      @(negedge cp);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 4'(i * 7 + 3);
    mem[8'h12] = 4'hA;
    mem[8'h05] = 4'h3;
    mem[8'h20] = 4'b0111;
    mem[8'h21] = 4'b0110;
    rst         = 1'b1;
    req_valid   = 2'b11;
    req_addr[0] = 8'h12;
    req_addr[1] = 8'h12;
    rsp_ready   = 2'b00;
    repeat (3) @(posedge cp);
    @(negedge cp);
    for (int i = 0; i < 2; i++) begin
      checkOutput("rst_req_ready", 32'(req_ready[i]), 0);
      checkIdleReset(i, "rst");
    end
    @(posedge cp); #1;
    rst       = 1'b0;
    req_valid = 2'b00;
    @(negedge cp);
    for (int i = 0; i < 2; i++) begin
      checkOutput("idle_req_ready", 32'(req_ready[i]), 1);
      checkOutput("idle_busy", 32'(busy[i]), 0);
    end

    $display("[TB] single read WAIT=1 with 5-cycle stall");
    applyStimulus(0, 8'h12, 5);
    $display("[TB] single read WAIT=3");
    applyStimulus(1, 8'h05, 0);
    $display("[TB] chained reads");
    chainReads();
    $display("[TB] reset during ACCESS");
    resetMidAccess();
    applyStimulus(1, 8'h05, 0);
    $display("[TB] parity words");
    applyStimulus(0, 8'h20, 0);
    applyStimulus(0, 8'h21, 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(k % 2, 8'($urandom_range(0, 255)), k);
    end

    repeat (3) @(posedge cp);
    @(negedge cp);
    checkOutput("q0_empty", exp_q0.size(), 0);
    checkOutput("q1_empty", exp_q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
